// File: rtl/rv32im_pkg.sv
// Shared definitions for the rv32im fetch front end.
package rv32im_pkg;

  localparam int RV_XLEN = 32;

  // One queue entry: {instruction, pc, err}
  localparam int FETCH_ENTRY_W = 2 * RV_XLEN + 1;

  // addi x0, x0, 0 -- handed to decode in place of a faulting fetch
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_BUS   = 2'd2,
    FETCH_DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/rv32im_fetch_fifo.sv
// Circular buffer of fetched entries with a combinational head read port.
module rv32im_fetch_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [W-1:0]           i_wdata,
  input  logic                   i_pop,
  output logic [W-1:0]           o_rdata,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic          w_pop;
  logic          w_push;

  // A pop of an empty queue is dropped; flush overrides push and pop.
  assign w_pop  = i_pop && (r_count != '0) && !i_flush;
  assign w_push = i_push && !i_flush;

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk_i) begin
    if (reset_i || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (w_push && !reset_i) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/rv32im_fetch_queue.sv
// Instruction fetch front end: Wishbone master behind the core arbiter,
// sequential prefetch into a small queue, flushed and restarted on redirect.
module rv32im_fetch_queue
  import rv32im_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            advance_i,
  output logic            data_ready_o,
  output logic [XLEN-1:0] instruction_o,
  output logic [XLEN-1:0] pc_o,
  output logic            fetch_err_o,
  output logic            ctrl_req_o,
  input  logic            ctrl_grant_i,
  input  logic [XLEN-1:0] master_dat_i,
  input  logic            ack_i,
  input  logic            err_i,
  output logic [XLEN-3:0] adr_o,
  output logic            cyc_o,
  output logic            stb_o,
  output logic [3:0]      sel_o
);

  localparam int EW = 2 * XLEN + 1;
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-3:0] r_adr;
  logic            r_halted;
  logic [CW-1:0]   w_count;
  logic            w_space;
  logic            w_bus_done;
  logic            w_in_bus;
  logic            w_push;
  logic [EW-1:0]   w_wdata;
  logic [EW-1:0]   w_head;
  logic            w_unused;

  assign w_space    = w_count < CW'(DEPTH);
  assign w_bus_done = ack_i | err_i;
  assign w_in_bus   = (r_state == FETCH_BUS);

  // Only a live (non-abandoned) transfer pushes; a redirect drops it.
  assign w_push  = w_in_bus && w_bus_done && !redirect_i;
  assign w_wdata = err_i ? {XLEN'(RV_NOP), r_fetch_pc, 1'b1}
                         : {master_dat_i,  r_fetch_pc, 1'b0};

  rv32im_fetch_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .i_flush (redirect_i),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (advance_i),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  assign data_ready_o  = (w_count != '0);
  assign instruction_o = w_head[EW-1 -: XLEN];
  assign pc_o          = w_head[XLEN:1];
  assign fetch_err_o   = w_head[0];
  assign sel_o         = 4'b1111;

  // Address is frozen for the whole transfer, including a drain after the
  // fetch PC has already moved to a redirect target.
  assign adr_o = (r_state == FETCH_BUS || r_state == FETCH_DRAIN) ? r_adr
                                                                  : r_fetch_pc[XLEN-1:2];

  assign w_unused = ^redirect_pc_i[1:0];

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= FETCH_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state and bus handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    ctrl_req_o  = 1'b0;
    cyc_o       = 1'b0;
    stb_o       = 1'b0;
    case (r_state)
      FETCH_IDLE: begin
        if (w_space && !r_halted && !redirect_i) w_state_nxt = FETCH_REQ;
      end
      FETCH_REQ: begin
        ctrl_req_o = 1'b1;
        if (redirect_i)                  w_state_nxt = FETCH_IDLE;
        else if (ctrl_grant_i && w_space) w_state_nxt = FETCH_BUS;
        else if (!w_space)               w_state_nxt = FETCH_IDLE;
      end
      FETCH_BUS: begin
        ctrl_req_o = 1'b1;
        cyc_o      = 1'b1;
        stb_o      = 1'b1;
        if (redirect_i) w_state_nxt = w_bus_done ? FETCH_IDLE : FETCH_DRAIN;
        else if (err_i) w_state_nxt = FETCH_IDLE;
        else if (ack_i) w_state_nxt = FETCH_REQ;
      end
      FETCH_DRAIN: begin
        ctrl_req_o = 1'b1;
        cyc_o      = 1'b1;
        stb_o      = 1'b1;
        if (w_bus_done) w_state_nxt = FETCH_IDLE;
      end
      default: w_state_nxt = FETCH_IDLE;
    endcase
  end

  // Fetch PC and halt flag; redirect beats any bus completion.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_fetch_pc <= RESET_PC;
      r_halted   <= 1'b0;
    end else if (redirect_i) begin
      r_fetch_pc <= {redirect_pc_i[XLEN-1:2], 2'b00};
      r_halted   <= 1'b0;
    end else if (w_in_bus && err_i) begin
      r_halted   <= 1'b1;
    end else if (w_in_bus && ack_i) begin
      r_fetch_pc <= r_fetch_pc + XLEN'(4);
    end
  end

  // Track the fetch address until a transfer starts, then hold it.
  always_ff @(posedge clk_i) begin
    if (reset_i)
      r_adr <= RESET_PC[XLEN-1:2];
    else if (r_state == FETCH_IDLE || r_state == FETCH_REQ)
      r_adr <= r_fetch_pc[XLEN-1:2];
  end

endmodule

// File: tb/tb_rv32im_fetch_queue.sv
// Bench for rv32im_fetch_queue: Wishbone slave + arbiter model, directed
// scenarios and a randomized stream checked against an ideal program order.
module tb_rv32im_fetch_queue;

  logic        clk = 1'b0;
  logic        reset_i, redirect_i, advance_i;
  logic [31:0] redirect_pc_i;
  logic        data_ready_o, fetch_err_o, ctrl_req_o, ctrl_grant_i;
  logic [31:0] instruction_o, pc_o, master_dat_i;
  logic        ack_i = 1'b0, err_i = 1'b0;
  logic [29:0] adr_o;
  logic        cyc_o, stb_o;
  logic [3:0]  sel_o;

  int errors = 0;
  int checks = 0;

  logic        gnt_r = 1'b0;
  int          gnt_pct = 100;
  int          ack_delay = 0;
  int          wcnt = 0;
  bit          rand_delay = 1'b0;
  bit          slave_auto = 1'b1;
  bit          man_ack = 1'b0;
  bit          err_en = 1'b0;
  logic [31:0] err_addr = '0;
  logic [29:0] xlog[$];

  always #5 clk = ~clk;

  assign ctrl_grant_i = gnt_r & ctrl_req_o;

  rv32im_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_i(clk), .reset_i(reset_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .advance_i(advance_i), .data_ready_o(data_ready_o), .instruction_o(instruction_o),
    .pc_o(pc_o), .fetch_err_o(fetch_err_o), .ctrl_req_o(ctrl_req_o), .ctrl_grant_i(ctrl_grant_i),
    .master_dat_i(master_dat_i), .ack_i(ack_i), .err_i(err_i), .adr_o(adr_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .sel_o(sel_o)
  );

  // Arbiter (grant held while requested) and slave (data = byte address).
  always @(negedge clk) begin
    if (!ctrl_req_o) gnt_r = 1'b0;
    else if (!gnt_r && int'($urandom_range(0, 99)) < gnt_pct) gnt_r = 1'b1;
    master_dat_i = {adr_o, 2'b00};
    if (!slave_auto) begin
      ack_i = man_ack;
      err_i = 1'b0;
    end else if (ack_i || err_i || !(cyc_o && stb_o)) begin
      ack_i = 1'b0; err_i = 1'b0; wcnt = 0;
    end else if (wcnt >= ack_delay) begin
      if (err_en && {adr_o, 2'b00} == err_addr) err_i = 1'b1;
      else                                      ack_i = 1'b1;
      wcnt = 0;
      if (rand_delay) ack_delay = int'($urandom_range(0, 3));
    end else begin
      wcnt++;
    end
  end

  // Log every completed bus transfer (word address).
  always @(posedge clk) begin
    if (cyc_o && stb_o && (ack_i || err_i)) xlog.push_back(adr_o);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1; redirect_i = 1'b0; advance_i = 1'b0;
    tick(); tick();
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; redirect_i = 1'b0; advance_i = 1'b0; redirect_pc_i = '0;
    tick(); tick();
    checks++; if (ctrl_req_o !== 1'b0)   begin errors++; $display("FAIL reset_req got %b want 0", ctrl_req_o); end
    checks++; if (cyc_o !== 1'b0)        begin errors++; $display("FAIL reset_cyc got %b want 0", cyc_o); end
    checks++; if (stb_o !== 1'b0)        begin errors++; $display("FAIL reset_stb got %b want 0", stb_o); end
    checks++; if (data_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", data_ready_o); end
    checks++; if (sel_o !== 4'hF)        begin errors++; $display("FAIL reset_sel got %h want f", sel_o); end
    reset_i = 1'b0;
  endtask

  task automatic test_fill();
    int base;
    do_reset();
    base = xlog.size();
    repeat (30) tick();
    checks++; if (xlog.size() != base + 4) begin errors++; $display("FAIL fill_count got %0d want 4", xlog.size() - base); end
    for (int i = 0; i < 4 && base + i < xlog.size(); i++) begin
      checks++; if (xlog[base+i] !== 30'(i)) begin errors++; $display("FAIL fill_adr%0d got %h want %h", i, xlog[base+i], 30'(i)); end
    end
    checks++; if (ctrl_req_o !== 1'b0)     begin errors++; $display("FAIL fill_req got %b want 0", ctrl_req_o); end
    checks++; if (data_ready_o !== 1'b1)   begin errors++; $display("FAIL fill_ready got %b want 1", data_ready_o); end
    checks++; if (pc_o !== 32'h0)          begin errors++; $display("FAIL fill_pc got %h want 0", pc_o); end
    checks++; if (instruction_o !== 32'h0) begin errors++; $display("FAIL fill_insn got %h want 0", instruction_o); end
    checks++; if (fetch_err_o !== 1'b0)    begin errors++; $display("FAIL fill_err got %b want 0", fetch_err_o); end
  endtask

  task automatic test_advance_one();
    int base;
    base = xlog.size();
    advance_i = 1'b1; tick(); advance_i = 1'b0;
    repeat (20) tick();
    checks++; if (pc_o !== 32'h4)          begin errors++; $display("FAIL adv_pc got %h want 4", pc_o); end
    checks++; if (instruction_o !== 32'h4) begin errors++; $display("FAIL adv_insn got %h want 4", instruction_o); end
    checks++; if (xlog.size() != base + 1) begin errors++; $display("FAIL adv_nfetch got %0d want 1", xlog.size() - base); end
    else begin
      checks++; if (xlog[base] !== 30'h4)  begin errors++; $display("FAIL adv_adr got %h want 4", xlog[base]); end
    end
  endtask

  task automatic test_redirect_drain();
    int base;
    ack_delay = 3;
    advance_i = 1'b1; tick(); advance_i = 1'b0;
    for (int k = 0; k < 20 && !cyc_o; k++) tick();
    checks++; if (cyc_o !== 1'b1) begin errors++; $display("FAIL drain_start got %b want 1", cyc_o); end
    base = xlog.size();
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_1002;
    tick();
    redirect_i = 1'b0;
    checks++; if (data_ready_o !== 1'b0) begin errors++; $display("FAIL drain_ready got %b want 0", data_ready_o); end
    checks++; if (cyc_o !== 1'b1)        begin errors++; $display("FAIL drain_cyc got %b want 1", cyc_o); end
    for (int k = 0; k < 20 && cyc_o; k++) tick();
    checks++; if (data_ready_o !== 1'b0) begin errors++; $display("FAIL drain_nopush got %b want 0", data_ready_o); end
    ack_delay = 0;
    repeat (25) tick();
    checks++; if (xlog.size() < base + 2) begin errors++; $display("FAIL drain_nlog got %0d want >=2", xlog.size() - base); end
    else begin
      checks++; if (xlog[base] !== 30'h5)     begin errors++; $display("FAIL drain_old_adr got %h want 5", xlog[base]); end
      checks++; if (xlog[base+1] !== 30'h400) begin errors++; $display("FAIL drain_new_adr got %h want 400", xlog[base+1]); end
    end
    checks++; if (pc_o !== 32'h1000)          begin errors++; $display("FAIL drain_pc got %h want 1000", pc_o); end
    checks++; if (instruction_o !== 32'h1000) begin errors++; $display("FAIL drain_insn got %h want 1000", instruction_o); end
  endtask

  task automatic test_error_halt();
    int base;
    err_en = 1'b1; err_addr = 32'h8;
    do_reset();
    base = xlog.size();
    repeat (30) tick();
    checks++; if (xlog.size() != base + 3) begin errors++; $display("FAIL err_nfetch got %0d want 3", xlog.size() - base); end
    checks++; if (ctrl_req_o !== 1'b0)     begin errors++; $display("FAIL err_halt_req got %b want 0", ctrl_req_o); end
    advance_i = 1'b1; tick(); tick(); advance_i = 1'b0;
    checks++; if (pc_o !== 32'h8)           begin errors++; $display("FAIL err_pc got %h want 8", pc_o); end
    checks++; if (fetch_err_o !== 1'b1)     begin errors++; $display("FAIL err_flag got %b want 1", fetch_err_o); end
    checks++; if (instruction_o !== 32'h13) begin errors++; $display("FAIL err_insn got %h want 13", instruction_o); end
    err_en = 1'b0;
    base = xlog.size();
    redirect_i = 1'b1; redirect_pc_i = 32'h100; tick(); redirect_i = 1'b0;
    repeat (30) tick();
    checks++; if (xlog.size() < base + 1) begin errors++; $display("FAIL err_resume got %0d want >=1", xlog.size() - base); end
    else begin
      checks++; if (xlog[base] !== 30'h40) begin errors++; $display("FAIL err_resume_adr got %h want 40", xlog[base]); end
    end
    checks++; if (pc_o !== 32'h100)      begin errors++; $display("FAIL err_resume_pc got %h want 100", pc_o); end
    checks++; if (fetch_err_o !== 1'b0)  begin errors++; $display("FAIL err_resume_flag got %b want 0", fetch_err_o); end
  endtask

  task automatic test_redirect_beats_ack();
    int base;
    do_reset();
    slave_auto = 1'b0;
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 20 && !cyc_o; k++) tick();
      man_ack = 1'b1; tick(); man_ack = 1'b0;
    end
    for (int k = 0; k < 20 && !cyc_o; k++) tick();
    checks++; if (data_ready_o !== 1'b1 || cyc_o !== 1'b1) begin errors++; $display("FAIL rba_setup got ready=%b cyc=%b want 1 1", data_ready_o, cyc_o); end
    man_ack = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h2000; advance_i = 1'b1;
    tick();
    man_ack = 1'b0; redirect_i = 1'b0; advance_i = 1'b0;
    checks++; if (data_ready_o !== 1'b0) begin errors++; $display("FAIL rba_ready got %b want 0", data_ready_o); end
    checks++; if (cyc_o !== 1'b0)        begin errors++; $display("FAIL rba_cyc got %b want 0", cyc_o); end
    base = xlog.size();
    slave_auto = 1'b1;
    repeat (20) tick();
    checks++; if (xlog.size() < base + 1) begin errors++; $display("FAIL rba_nlog got %0d want >=1", xlog.size() - base); end
    else begin
      checks++; if (xlog[base] !== 30'h800) begin errors++; $display("FAIL rba_adr got %h want 800", xlog[base]); end
    end
    checks++; if (pc_o !== 32'h2000)          begin errors++; $display("FAIL rba_pc got %h want 2000", pc_o); end
    checks++; if (instruction_o !== 32'h2000) begin errors++; $display("FAIL rba_insn got %h want 2000", instruction_o); end
  endtask

  task automatic test_reset_mid_bus();
    int base;
    do_reset();
    ack_delay = 5;
    base = xlog.size();
    for (int k = 0; k < 200 && !(xlog.size() == base + 3 && cyc_o); k++) tick();
    checks++; if (!(cyc_o === 1'b1 && data_ready_o === 1'b1)) begin errors++; $display("FAIL rmb_setup got cyc=%b ready=%b want 1 1", cyc_o, data_ready_o); end
    reset_i = 1'b1; tick();
    checks++; if ({ctrl_req_o, cyc_o, stb_o, data_ready_o} !== 4'b0000) begin
      errors++; $display("FAIL rmb_outputs got %b want 0000", {ctrl_req_o, cyc_o, stb_o, data_ready_o});
    end
    reset_i = 1'b0; ack_delay = 0;
    base = xlog.size();
    repeat (20) tick();
    checks++; if (xlog.size() < base + 1) begin errors++; $display("FAIL rmb_nlog got %0d want >=1", xlog.size() - base); end
    else begin
      checks++; if (xlog[base] !== 30'h0) begin errors++; $display("FAIL rmb_adr got %h want 0", xlog[base]); end
    end
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL rmb_pc got %h want 0", pc_o); end
  endtask

  // Decode must see the program order from the last redirect target,
  // ending with a NOP error entry at the faulting address, regardless of
  // bus timing, grant delay or consumption rate.
  task automatic test_random_stream();
    logic [31:0] mpc, tgt;
    bit          mhalt;
    int          pops;
    do_reset();
    rand_delay = 1'b1; gnt_pct = 60;
    mpc = 32'h0; mhalt = 1'b0; pops = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 3) begin
        tgt = $urandom;
        if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
        redirect_i = 1'b1; redirect_pc_i = tgt; advance_i = $urandom_range(0, 1);
        err_en = ($urandom_range(0, 2) == 0);
        err_addr = {tgt[31:2], 2'b00} + 32'(4 * $urandom_range(0, 6));
        mpc = {tgt[31:2], 2'b00}; mhalt = 1'b0;
      end else begin
        redirect_i = 1'b0;
        advance_i = $urandom_range(0, 1);
        if (data_ready_o && mhalt) begin
          checks++; errors++;
          $display("FAIL rnd_after_halt got entry pc=%h want none", pc_o);
          mhalt = 1'b0;
        end else if (advance_i && data_ready_o) begin
          checks++;
          if (pc_o !== mpc || fetch_err_o !== (err_en && mpc == err_addr) ||
              instruction_o !== ((err_en && mpc == err_addr) ? 32'h13 : mpc)) begin
            errors++;
            $display("FAIL rnd_entry got pc=%h insn=%h err=%b want pc=%h err=%b",
                     pc_o, instruction_o, fetch_err_o, mpc, (err_en && mpc == err_addr));
          end
          if (err_en && mpc == err_addr) mhalt = 1'b1;
          mpc = mpc + 32'd4;
          pops++;
        end
      end
      tick();
    end
    redirect_i = 1'b0; advance_i = 1'b0;
    checks++; if (pops < 50) begin errors++; $display("FAIL rnd_pops got %0d want >=50", pops); end
    rand_delay = 1'b0; gnt_pct = 100; ack_delay = 0; err_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_advance_one();
    test_redirect_drain();
    test_error_halt();
    test_redirect_beats_ack();
    test_reset_mid_bus();
    test_random_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
